// File: rtl/cv32e40p_rf_recovery_ctrl.sv
// Register-file recovery controller.
// Sweeps the core RF through three backup read ports into a shadow copy and,
// on request, writes that copy back through write ports A/B with recover set.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | no activity; accepts backup or recovery requests
// BACKUP  | reading three RF entries per cycle into the shadow array
// RECOVER | writing two shadow entries per cycle back into the RF
module cv32e40p_rf_recovery_ctrl #(
    parameter bit FPU    = 1'b0,
    parameter int ADDR_W = 6
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              backup_en_i,
    input  logic              recover_req_i,
    output logic              regfile_backup_o,
    output logic [ADDR_W-1:0] regfile_raddr_ra_o,
    output logic [ADDR_W-1:0] regfile_raddr_rb_o,
    output logic [ADDR_W-1:0] regfile_raddr_rc_o,
    input  logic [31:0]       regfile_rdata_ra_i,
    input  logic [31:0]       regfile_rdata_rb_i,
    input  logic [31:0]       regfile_rdata_rc_i,
    output logic              recover_o,
    output logic [ADDR_W-1:0] regfile_waddr_a_o,
    output logic [ADDR_W-1:0] regfile_waddr_b_o,
    output logic [31:0]       regfile_wdata_a_o,
    output logic [31:0]       regfile_wdata_b_o,
    output logic              regfile_we_a_o,
    output logic              regfile_we_b_o,
    output logic              snapshot_valid_o,
    output logic              busy_o,
    output logic              recover_done_o,
    output logic              recover_err_o
);

    localparam int NREGS = FPU ? 64 : 32;
    localparam int IW    = $clog2(NREGS);
    // One extra bit so ptr+2 / ptr+3 never wrap before the range compare.
    localparam int PW    = ADDR_W + 1;
    localparam logic [PW-1:0] NREGS_P  = PW'(NREGS);
    localparam logic [PW-1:0] LAST_REC = PW'(NREGS - 2);

    typedef enum logic [1:0] {IDLE, BACKUP, RECOVER} state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] ptr_q, ptr_d;
    logic          snap_q, snap_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic          sweep_last;

    logic [31:0]   shadow [NREGS];

    logic [PW-1:0] rd_addr [3];
    logic [2:0]    rd_ok;
    logic [31:0]   rd_data [3];

    assign rd_data[0] = regfile_rdata_ra_i;
    assign rd_data[1] = regfile_rdata_rb_i;
    assign rd_data[2] = regfile_rdata_rc_i;

    // Backup read window: ptr..ptr+2, each flagged if it lies inside the RF.
    always_comb begin
        for (int k = 0; k < 3; k++) begin
            rd_addr[k] = ptr_q + PW'(k);
            rd_ok[k]   = rd_addr[k] < NREGS_P;
        end
        sweep_last = (ptr_q + PW'(3)) >= NREGS_P;
    end

    // State, pointer, sticky snapshot flag and single-cycle pulses.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            snap_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            snap_q  <= snap_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    // Shadow capture; the array carries no reset, out-of-range slots are skipped.
    always_ff @(posedge clk_i) begin
        if (!rst_i && state_q == BACKUP) begin
            for (int k = 0; k < 3; k++) begin
                if (rd_ok[k]) begin
                    shadow[rd_addr[k][IW-1:0]] <= rd_data[k];
                end
            end
        end
    end

    // Next-state and pointer sequencing; a recovery request outranks backup.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        snap_d  = snap_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (recover_req_i) begin
                    if (snap_q) begin
                        state_d = RECOVER;
                        ptr_d   = '0;
                    end else begin
                        err_d = 1'b1;
                    end
                end else if (backup_en_i) begin
                    state_d = BACKUP;
                    ptr_d   = '0;
                end
            end
            BACKUP: begin
                if (sweep_last) begin
                    snap_d = 1'b1;
                end
                if (recover_req_i) begin
                    // The capture of this cycle still lands; the sweep is abandoned.
                    ptr_d = '0;
                    if (snap_q) begin
                        state_d = RECOVER;
                    end else begin
                        state_d = IDLE;
                        err_d   = 1'b1;
                    end
                end else if (sweep_last) begin
                    ptr_d   = '0;
                    state_d = backup_en_i ? BACKUP : IDLE;
                end else begin
                    ptr_d = ptr_q + PW'(3);
                end
            end
            RECOVER: begin
                if (ptr_q == LAST_REC) begin
                    state_d = IDLE;
                    ptr_d   = '0;
                    done_d  = 1'b1;
                end else begin
                    ptr_d = ptr_q + PW'(2);
                end
            end
            default: begin
                state_d = IDLE;
                ptr_d   = '0;
            end
        endcase
    end

    // Port drive, decoded from the registered state, pointer and shadow.
    always_comb begin
        regfile_backup_o   = 1'b0;
        regfile_raddr_ra_o = '0;
        regfile_raddr_rb_o = '0;
        regfile_raddr_rc_o = '0;
        recover_o          = 1'b0;
        regfile_we_a_o     = 1'b0;
        regfile_we_b_o     = 1'b0;
        regfile_waddr_a_o  = '0;
        regfile_waddr_b_o  = '0;
        regfile_wdata_a_o  = '0;
        regfile_wdata_b_o  = '0;
        case (state_q)
            BACKUP: begin
                regfile_backup_o   = 1'b1;
                regfile_raddr_ra_o = rd_ok[0] ? rd_addr[0][ADDR_W-1:0] : '0;
                regfile_raddr_rb_o = rd_ok[1] ? rd_addr[1][ADDR_W-1:0] : '0;
                regfile_raddr_rc_o = rd_ok[2] ? rd_addr[2][ADDR_W-1:0] : '0;
            end
            RECOVER: begin
                // ptr is always even here, so ptr+1 stays inside the array.
                recover_o         = 1'b1;
                regfile_we_a_o    = 1'b1;
                regfile_we_b_o    = 1'b1;
                regfile_waddr_a_o = ptr_q[ADDR_W-1:0];
                regfile_waddr_b_o = ptr_q[ADDR_W-1:0] + ADDR_W'(1);
                regfile_wdata_a_o = shadow[ptr_q[IW-1:0]];
                regfile_wdata_b_o = shadow[ptr_q[IW-1:0] + IW'(1)];
            end
            default: begin
            end
        endcase
    end

    assign snapshot_valid_o = snap_q;
    assign busy_o           = (state_q != IDLE);
    assign recover_done_o   = done_q;
    assign recover_err_o    = err_q;

endmodule

// File: tb/tb_cv32e40p_rf_recovery_ctrl.sv
// Scoreboard bench: stimulus pushes expected read windows, write pairs and
// done/err events; negedge monitors pop and compare whenever the DUT shows one.
module tb_cv32e40p_rf_recovery_ctrl;

    typedef struct packed {
        logic [5:0] a;
        logic [5:0] b;
        logic [5:0] c;
    } rd_t;

    typedef struct packed {
        logic [1:0]  we;
        logic [5:0]  wa;
        logic [31:0] da;
        logic [5:0]  wb;
        logic [31:0] db;
    } wr_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    logic be0, rq0, bk0, rec0, wea0, web0, sv0, busy0, done0, err0;
    logic be1, rq1, bk1, rec1, wea1, web1, sv1, busy1, done1, err1;
    logic [5:0]  ra0, rb0, rc0, wa0, wb0, ra1, rb1, rc1, wa1, wb1;
    logic [31:0] da0, db0, dc0, wda0, wdb0, da1, db1, dc1, wda1, wdb1;

    logic [31:0] rf0 [64];
    logic [31:0] rf1 [64];
    logic [31:0] exp_sh0 [32];
    logic [31:0] exp_sh1 [64];

    assign da0 = rf0[ra0];
    assign db0 = rf0[rb0];
    assign dc0 = rf0[rc0];
    assign da1 = rf1[ra1];
    assign db1 = rf1[rb1];
    assign dc1 = rf1[rc1];

    rd_t rdq0[$], rdq1[$];
    wr_t wrq0[$], wrq1[$];
    int  evq0[$], evq1[$];

    int total = 0;
    int bad   = 0;
    int run1  = 0;
    int max1  = 0;

    cv32e40p_rf_recovery_ctrl #(.FPU(1'b0), .ADDR_W(6)) u_dut0 (
        .clk_i(clk), .rst_i(rst), .backup_en_i(be0), .recover_req_i(rq0),
        .regfile_backup_o(bk0),
        .regfile_raddr_ra_o(ra0), .regfile_raddr_rb_o(rb0), .regfile_raddr_rc_o(rc0),
        .regfile_rdata_ra_i(da0), .regfile_rdata_rb_i(db0), .regfile_rdata_rc_i(dc0),
        .recover_o(rec0),
        .regfile_waddr_a_o(wa0), .regfile_waddr_b_o(wb0),
        .regfile_wdata_a_o(wda0), .regfile_wdata_b_o(wdb0),
        .regfile_we_a_o(wea0), .regfile_we_b_o(web0),
        .snapshot_valid_o(sv0), .busy_o(busy0),
        .recover_done_o(done0), .recover_err_o(err0)
    );

    cv32e40p_rf_recovery_ctrl #(.FPU(1'b1), .ADDR_W(6)) u_dut1 (
        .clk_i(clk), .rst_i(rst), .backup_en_i(be1), .recover_req_i(rq1),
        .regfile_backup_o(bk1),
        .regfile_raddr_ra_o(ra1), .regfile_raddr_rb_o(rb1), .regfile_raddr_rc_o(rc1),
        .regfile_rdata_ra_i(da1), .regfile_rdata_rb_i(db1), .regfile_rdata_rc_i(dc1),
        .recover_o(rec1),
        .regfile_waddr_a_o(wa1), .regfile_waddr_b_o(wb1),
        .regfile_wdata_a_o(wda1), .regfile_wdata_b_o(wdb1),
        .regfile_we_a_o(wea1), .regfile_we_b_o(web1),
        .snapshot_valid_o(sv1), .busy_o(busy1),
        .recover_done_o(done1), .recover_err_o(err1)
    );

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic unexpected(input string nm);
        total++;
        bad++;
        $display("FAIL %s: output seen with nothing expected", nm);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [5:0] ma(input int x, input int n);
        return (x < n) ? 6'(x) : 6'd0;
    endfunction

    // Expected read windows for one sweep; shadow model takes the given data base.
    task automatic push_sweep0(input int last_p, input logic [31:0] base);
        for (int p = 0; p <= last_p; p += 3) begin
            rdq0.push_back('{a: ma(p, 32), b: ma(p + 1, 32), c: ma(p + 2, 32)});
            for (int k = 0; k < 3; k++)
                if (p + k < 32) exp_sh0[p + k] = base + 32'(p + k);
        end
    endtask

    task automatic push_sweep1(input logic [31:0] base);
        for (int p = 0; p < 64; p += 3) begin
            rdq1.push_back('{a: ma(p, 64), b: ma(p + 1, 64), c: ma(p + 2, 64)});
            for (int k = 0; k < 3; k++)
                if (p + k < 64) exp_sh1[p + k] = base + 32'(p + k);
        end
    endtask

    task automatic push_rec0(input int npairs);
        for (int i = 0; i < npairs; i++)
            wrq0.push_back('{we: 2'b11, wa: 6'(2 * i), da: exp_sh0[2 * i],
                             wb: 6'(2 * i + 1), db: exp_sh0[2 * i + 1]});
    endtask

    task automatic push_rec1(input int npairs);
        for (int i = 0; i < npairs; i++)
            wrq1.push_back('{we: 2'b11, wa: 6'(2 * i), da: exp_sh1[2 * i],
                             wb: 6'(2 * i + 1), db: exp_sh1[2 * i + 1]});
    endtask

    // Monitor for the FPU=0 instance.
    always @(negedge clk) begin
        rd_t r;
        wr_t w;
        int  e;
        if (bk0 === 1'b1) begin
            if (rdq0.size() == 0) unexpected("rd0");
            else begin
                r = rdq0.pop_front();
                chk("rd0", {ra0, rb0, rc0}, r);
            end
        end
        if (rec0 === 1'b1) begin
            if (wrq0.size() == 0) unexpected("wr0");
            else begin
                w = wrq0.pop_front();
                chk("wr0", {wea0, web0, wa0, wda0, wb0, wdb0}, w);
            end
        end else if (wea0 !== 1'b0 || web0 !== 1'b0) begin
            unexpected("we0_without_recover");
        end
        if (err0 === 1'b1) begin
            if (evq0.size() == 0) unexpected("err0");
            else begin
                e = evq0.pop_front();
                chk("ev0_err", 1, e);
            end
        end
        if (done0 === 1'b1) begin
            if (evq0.size() == 0) unexpected("done0");
            else begin
                e = evq0.pop_front();
                chk("ev0_done", 2, e);
            end
        end
    end

    // Monitor for the FPU=1 instance, also tracking the longest backup run.
    always @(negedge clk) begin
        rd_t r;
        wr_t w;
        int  e;
        if (bk1 === 1'b1) begin
            run1++;
            if (rdq1.size() == 0) unexpected("rd1");
            else begin
                r = rdq1.pop_front();
                chk("rd1", {ra1, rb1, rc1}, r);
            end
        end else begin
            if (run1 > max1) max1 = run1;
            run1 = 0;
        end
        if (rec1 === 1'b1) begin
            if (wrq1.size() == 0) unexpected("wr1");
            else begin
                w = wrq1.pop_front();
                chk("wr1", {wea1, web1, wa1, wda1, wb1, wdb1}, w);
            end
        end
        if (err1 === 1'b1) begin
            if (evq1.size() == 0) unexpected("err1");
            else begin
                e = evq1.pop_front();
                chk("ev1_err", 1, e);
            end
        end
        if (done1 === 1'b1) begin
            if (evq1.size() == 0) unexpected("done1");
            else begin
                e = evq1.pop_front();
                chk("ev1_done", 2, e);
            end
        end
    end

    initial begin
        #100000;
        bad++;
        $display("FAIL watchdog: time limit reached");
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        be0 = 1'b0; rq0 = 1'b0; be1 = 1'b0; rq1 = 1'b0;
        for (int i = 0; i < 64; i++) begin
            rf0[i] = 32'h1000 + 32'(i);
            rf1[i] = 32'h1000 + 32'(i);
        end
        tick();
        tick();
        @(negedge clk);
        chk("rst_busy0", busy0, 0);
        chk("rst_snap0", sv0, 0);
        chk("rst_outs0", {bk0, rec0, wea0, web0, done0, err0}, 0);
        chk("rst_addr0", {ra0, rb0, rc0, wa0, wb0}, 0);
        chk("rst_busy1", busy1, 0);
        tick();
        rst = 1'b0;

        // recovery without a snapshot is rejected
        rq0 = 1'b1;
        evq0.push_back(1);
        tick();
        rq0 = 1'b0;
        @(negedge clk);
        chk("err_busy0", busy0, 0);
        chk("err_pulse0", err0, 1);
        tick();
        chk("err_snap0", sv0, 0);

        // one full sweep of x_i = 0x1000+i
        be0 = 1'b1;
        push_sweep0(30, 32'h1000);
        repeat (11) tick();
        be0 = 1'b0;
        @(negedge clk);
        chk("snap_before_end0", sv0, 0);
        chk("busy_in_sweep0", busy0, 1);
        tick();
        @(negedge clk);
        chk("snap_after_sweep0", sv0, 1);
        chk("idle_after_sweep0", busy0, 0);

        // restore; done shows up in cycle 17
        tick();
        rq0 = 1'b1;
        push_rec0(16);
        evq0.push_back(2);
        tick();
        rq0 = 1'b0;
        repeat (16) tick();
        @(negedge clk);
        chk("done_cycle17", {done0, rec0, busy0}, 3'b100);
        tick();

        // sweep with new data aborted by a request while ptr=15
        for (int i = 0; i < 64; i++) rf0[i] = 32'h2000 + 32'(i);
        be0 = 1'b1;
        push_sweep0(15, 32'h2000);
        repeat (6) tick();
        rq0 = 1'b1;
        be0 = 1'b0;
        push_rec0(16);
        evq0.push_back(2);
        tick();
        rq0 = 1'b0;
        @(negedge clk);
        chk("abort_to_recover0", {rec0, bk0}, 2'b10);
        repeat (18) tick();

        // reset during cycle 8 of a restore
        rq0 = 1'b1;
        push_rec0(8);
        tick();
        rq0 = 1'b0;
        repeat (7) tick();
        rst = 1'b1;
        tick();
        @(negedge clk);
        chk("rstmid_writes0", {rec0, wea0, web0}, 0);
        chk("rstmid_snap0", sv0, 0);
        chk("rstmid_busy0", busy0, 0);
        tick();
        rst = 1'b0;
        tick();

        // FPU=1: two back-to-back sweeps, data changes for the second one
        be1 = 1'b1;
        push_sweep1(32'h1000);
        push_sweep1(32'h2000);
        repeat (23) tick();
        for (int i = 0; i < 64; i++) rf1[i] = 32'h2000 + 32'(i);
        repeat (21) tick();
        be1 = 1'b0;
        @(negedge clk);
        chk("sweep2_last1", bk1, 1);
        tick();
        @(negedge clk);
        chk("idle_after_sweeps1", {busy1, sv1}, 2'b01);
        tick();
        rq1 = 1'b1;
        push_rec1(32);
        evq1.push_back(2);
        tick();
        rq1 = 1'b0;
        repeat (34) tick();

        chk("left_rd0", rdq0.size(), 0);
        chk("left_wr0", wrq0.size(), 0);
        chk("left_ev0", evq0.size(), 0);
        chk("left_rd1", rdq1.size(), 0);
        chk("left_wr1", wrq1.size(), 0);
        chk("left_ev1", evq1.size(), 0);
        chk("backup_run1", max1, 44);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
